// File: rtl/result_tx_scheduler.sv
// result_tx_scheduler
//   Buffers 16-bit writeback results in a small circular FIFO and serialises
//   each word to a byte-wide UART transmitter, high byte first.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   done       in   writeback store-complete strobe (one word per cycle)
//   ResultW    in   [15:0] result word, sampled when done=1
//   tx_ready   in   transmitter accepts a byte this cycle
//   tx_valid   out  byte on tx_data is offered
//   tx_data    out  [7:0] offered byte
//   stall      out  hold the pipeline (FIFO nearly full)
//   overflow   out  sticky: a result word was dropped
//   fifo_count out  [clog2(DEPTH):0] words buffered, not yet dequeued
//   busy       out  FIFO non-empty or a word is in flight
module result_tx_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     done,
    input  logic [15:0]              ResultW,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic                     stall,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StSendHi,
        StSendLo
    } state_e;

    state_e          r_state;
    state_e          w_state_next;

    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_hold;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push  = done && (!w_full || w_pop);
    assign w_drop  = done && w_full && !w_pop;

    // One slot of slack covers a done already in flight when stall rises.
    assign stall      = (r_count >= (AW+1)'(DEPTH - 1));
    assign overflow   = r_overflow;
    assign fifo_count = r_count;
    assign busy       = !w_empty || (r_state != StIdle);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StSendHi;
                end
            end
            StSendHi: begin
                tx_valid = 1'b1;
                tx_data  = r_hold[15:8];
                if (tx_ready) begin
                    w_state_next = StSendLo;
                end
            end
            StSendLo: begin
                tx_valid = 1'b1;
                tx_data  = r_hold[7:0];
                if (tx_ready) begin
                    // Chain straight into the next word to avoid an idle cycle.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StSendHi;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_hold     <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_hold <= r_mem[r_rptr];
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem[r_wptr] <= ResultW;
        end
    end

endmodule

// File: tb/tb_result_tx_scheduler.sv
module tb_result_tx_scheduler;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        done = 1'b0;
    logic [15:0] ResultW = 16'h0000;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        stall;
    logic        overflow;
    logic [2:0]  fifo_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of buffered words plus the word being sent.
    logic [15:0] m_q[$];
    bit          m_active = 0;
    logic [15:0] m_hold = 16'h0000;
    bit          m_lo = 0;
    bit          m_ovf = 0;

    logic [7:0]  cap[$];

    always #5 clk = ~clk;

    result_tx_scheduler #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .done      (done),
        .ResultW   (ResultW),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .stall     (stall),
        .overflow  (overflow),
        .fifo_count(fifo_count),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit d, input logic [15:0] w, input bit r, input bit rst);
        bit xfer_lo;
        bit pop;
        bit full;
        if (!rst) begin
            m_q.delete();
            m_active = 0;
            m_hold   = 16'h0000;
            m_lo     = 0;
            m_ovf    = 0;
            return;
        end
        xfer_lo = m_active && m_lo && r;
        full    = (m_q.size() == DEPTH);
        pop     = (m_q.size() != 0) && (!m_active || xfer_lo);
        if (m_active && r && !m_lo) m_lo = 1;
        else if (xfer_lo) m_active = 0;
        if (pop) begin
            m_hold   = m_q.pop_front();
            m_active = 1;
            m_lo     = 0;
        end
        if (d) begin
            if (!full || pop) m_q.push_back(w);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_data;
        exp_data = !m_active ? 8'h00 : (m_lo ? m_hold[7:0] : m_hold[15:8]);
        check("tx_valid", 32'(tx_valid), 32'(m_active));
        check("tx_data", 32'(tx_data), 32'(exp_data));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("stall", 32'(stall), 32'(m_q.size() >= DEPTH - 1));
        check("busy", 32'(busy), 32'(m_q.size() != 0 || m_active));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Inputs change just after the falling edge; outputs are checked at the next one.
    task automatic step(input bit d, input logic [15:0] w, input bit r, input bit rst);
        done     = d;
        ResultW  = w;
        tx_ready = r;
        reset_n  = rst;
        #1;
        if (rst && tx_valid && tx_ready) cap.push_back(tx_data);
        @(posedge clk);
        model_update(d, w, r, rst);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        cap.delete();
    endtask

    task automatic check_cap(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            check(tag, 32'(cap[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [7:0] exp_b[$];
        int         i;
        int         budget;
        bit         d;

        @(negedge clk);
        do_reset();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Single word
        step(1'b1, 16'hA55A, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0000, 1'b1, 1'b1);
        exp_b = '{8'hA5, 8'h5A};
        check_cap("single_bytes", exp_b);
        check("single_busy", 32'(busy), 0);

        // Backpressure
        cap.delete();
        step(1'b1, 16'h1234, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("bp_valid", 32'(tx_valid), 1);
        check("bp_data", 32'(tx_data), 32'h12);
        for (int k = 0; k < 3; k++) step(1'b0, 16'h0000, 1'b1, 1'b1);
        exp_b = '{8'h12, 8'h34};
        check_cap("bp_bytes", exp_b);

        // Fill and overflow
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 16'(k), 1'b0, 1'b1);
        check("fill_stall", 32'(stall), 1);
        check("fill_count3", 32'(fifo_count), 3);
        step(1'b1, 16'h0005, 1'b0, 1'b1);
        check("fill_count4", 32'(fifo_count), 4);
        check("fill_no_ovf", 32'(overflow), 0);
        step(1'b1, 16'h0006, 1'b0, 1'b1);
        check("fill_ovf", 32'(overflow), 1);

        // Push and pop in the same cycle at full
        do_reset();
        for (int k = 1; k <= 5; k++) step(1'b1, 16'(k), 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        step(1'b1, 16'h0AAA, 1'b1, 1'b1);
        check("pp_count", 32'(fifo_count), 4);
        check("pp_ovf", 32'(overflow), 0);
        for (int k = 0; k < 14; k++) step(1'b0, 16'h0000, 1'b1, 1'b1);
        exp_b = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04,
                  8'h00, 8'h05, 8'h0A, 8'hAA};
        check_cap("pp_bytes", exp_b);
        check("pp_idle", 32'(busy), 0);

        // Wrap with random backpressure, producer honours stall
        do_reset();
        i = 0;
        budget = 0;
        while ((i < 10 || busy) && budget < 400) begin
            d = (i < 10) && !stall;
            step(d, 16'h0100 + 16'(i), 1'($urandom_range(0, 1)), 1'b1);
            if (d) i++;
            budget++;
        end
        check("wrap_budget", 32'(budget < 400), 1);
        exp_b.delete();
        for (int k = 0; k < 10; k++) begin
            exp_b.push_back(8'h01);
            exp_b.push_back(8'(k));
        end
        check_cap("wrap_bytes", exp_b);
        check("wrap_ovf", 32'(overflow), 0);

        // Reset while sending the low byte with two words buffered
        do_reset();
        step(1'b1, 16'h1111, 1'b0, 1'b1);
        step(1'b1, 16'h2222, 1'b0, 1'b1);
        step(1'b1, 16'h3333, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        check("mid_count", 32'(fifo_count), 2);
        check("mid_lo", 32'(tx_data), 32'h11);
        step(1'b1, 16'h9999, 1'b0, 1'b0);
        check("mid_rst_valid", 32'(tx_valid), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_busy", 32'(busy), 0);
        cap.delete();
        step(1'b1, 16'h4455, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0000, 1'b1, 1'b1);
        exp_b = '{8'h44, 8'h55};
        check_cap("post_rst_bytes", exp_b);

        // Fully random traffic including overflow and occasional resets
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
